// File: rtl/medidor_desempenho_oci_pkg.sv
// rtl/medidor_desempenho_oci_pkg.sv - jdo field map, FSM state and op encodings for the OCI monitor
package medidor_desempenho_oci_pkg;

  localparam int JDO_W          = 38;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_ADDR_MSB   = 25;
  localparam int JDO_WDATA_LSB  = 3;
  localparam int JDO_WDATA_MSB  = 34;
  localparam int JDO_ERRCLR_BIT = 33;
  localparam int JDO_WRPROT_BIT = 35;
  localparam int JADDR_W        = JDO_ADDR_MSB - JDO_ADDR_LSB + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_JCMD, ST_JRD, ST_CRD} state_e;
  typedef enum logic [1:0] {READ_SETADDR, READ_INC, WRITE_INC} op_e;

  function automatic logic [JADDR_W-1:0] addr_wrap_inc(input logic [JADDR_W-1:0] a, input int depth);
    return (a == JADDR_W'(depth - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/medidor_desempenho_nios2_oci_monitor_ram.sv
// rtl/medidor_desempenho_nios2_oci_monitor_ram.sv - single-port DEPTHx32 synchronous RAM, 1-cycle read latency
module medidor_desempenho_nios2_oci_monitor_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Read-during-write returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/medidor_desempenho_nios2_oci_monitor.sv
// rtl/medidor_desempenho_nios2_oci_monitor.sv - JTAG ocimem command decoder and Avalon-MM port sharing one debug RAM; OCIMON_WRPROT_EN adds a CPU write-protect bit
module medidor_desempenho_nios2_oci_monitor
  import medidor_desempenho_oci_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam logic [JADDR_W:0] DEPTH_X = (JADDR_W+1)'(DEPTH);

  state_e               state_q;
  op_e                  op_q;
  logic [JADDR_W-1:0]   addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          mon_dreg_q;
  logic                 ready_q;
  logic                 error_q;
  logic                 wr_protect;
  logic                 strobe_any;
  logic                 in_range;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;
  logic                 unused_jdo;

  assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  // The JTAG address is 9 bits wide regardless of DEPTH, so it can point past the RAM.
  assign in_range   = ({1'b0, addr_q} < DEPTH_X);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef OCIMON_WRPROT_EN
  logic protect_q;
  always_ff @(posedge clk) begin
    if (reset) protect_q <= 1'b0;
    else if (state_q == ST_IDLE && take_action_ocimem_a) protect_q <= jdo[JDO_WRPROT_BIT];
  end
  assign wr_protect = protect_q;
`else
  assign wr_protect = 1'b0;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = avs_address;
    ram_wdata = avs_writedata;
    if (state_q == ST_JCMD) begin
      ram_addr  = addr_q[ADDR_W-1:0];
      ram_wdata = wdata_q;
      ram_we    = (op_q == WRITE_INC) && in_range && !reset;
    end else if (state_q == ST_IDLE && !strobe_any && avs_write) begin
      ram_we = !wr_protect && !reset;
    end
  end

  always_comb begin
    avs_waitrequest = 1'b0;
    avs_readdata    = '0;
    case (state_q)
      ST_IDLE: avs_waitrequest = strobe_any ? (avs_read | avs_write) : (avs_read & ~avs_write);
      ST_JCMD, ST_JRD: avs_waitrequest = avs_read | avs_write;
      ST_CRD: avs_readdata = ram_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= READ_SETADDR;
      addr_q     <= '0;
      wdata_q    <= '0;
      mon_dreg_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (strobe_any && state_q != ST_IDLE) error_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (strobe_any) begin
            ready_q <= 1'b0;
            wdata_q <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            state_q <= ST_JCMD;
            if (take_action_ocimem_a) begin
              op_q   <= READ_SETADDR;
              addr_q <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
              if (jdo[JDO_ERRCLR_BIT]) error_q <= 1'b0;
            end else if (take_no_action_ocimem_a) begin
              op_q <= READ_INC;
            end else begin
              op_q <= WRITE_INC;
            end
          end else if (avs_read && !avs_write) begin
            state_q <= ST_CRD;
          end
        end
        ST_JCMD: begin
          if (!in_range) error_q <= 1'b1;
          if (op_q == WRITE_INC) begin
            if (in_range) addr_q <= addr_wrap_inc(addr_q, DEPTH);
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_JRD;
          end
        end
        ST_JRD: begin
          mon_dreg_q <= in_range ? ram_rdata : '0;
          ready_q    <= 1'b1;
          // ocimem_a leaves the pointer on the word it just loaded.
          if (op_q != READ_SETADDR && in_range) addr_q <= addr_wrap_inc(addr_q, DEPTH);
          state_q    <= ST_IDLE;
        end
        ST_CRD: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  medidor_desempenho_nios2_oci_monitor_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_medidor_desempenho_nios2_oci_monitor.sv
// tb/tb_medidor_desempenho_nios2_oci_monitor.sv - directed plus random bench with behavioural RAM/pointer model
module tb_medidor_desempenho_nios2_oci_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [31:0] MonDReg;
  logic        mon_ready, mon_error;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [256];
  int          jaddr_m = 0;
  bit          err_m   = 0;
  bit          prot_m  = 0;
  logic [31:0] dreg_m  = '0;

  always #5 clk = ~clk;

  medidor_desempenho_nios2_oci_monitor dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_na),
    .take_action_ocimem_b    (take_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mkjdo(input int a, input bit clr, input bit prot);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[25:17] = 9'(a);
    j[33] = clr;
    j[35] = prot;
    return j;
  endfunction

  task automatic jtag_a(input logic [37:0] j, input string tag);
    int a;
    a = int'(j[25:17]);
    jdo = j; take_a = 1'b1;
    step();
    take_a = 1'b0;
    chk({tag, ".ready_lo"}, 32'(mon_ready), 32'd0);
    if (j[33]) err_m = 0;
`ifdef OCIMON_WRPROT_EN
    prot_m = j[35];
`endif
    jaddr_m = a;
    if (a >= 256) begin err_m = 1; dreg_m = '0; end
    else dreg_m = mem_m[a];
    step(); step();
    chk({tag, ".dreg"}, MonDReg, dreg_m);
    chk({tag, ".ready"}, 32'(mon_ready), 32'd1);
    chk({tag, ".err"}, 32'(mon_error), 32'(err_m));
  endtask

  task automatic jtag_na(input string tag);
    jdo = 38'({$urandom, $urandom}); take_na = 1'b1;
    step();
    take_na = 1'b0;
    step(); step();
    dreg_m  = mem_m[jaddr_m];
    jaddr_m = (jaddr_m + 1) % 256;
    chk({tag, ".dreg"}, MonDReg, dreg_m);
    chk({tag, ".ready"}, 32'(mon_ready), 32'd1);
    chk({tag, ".err"}, 32'(mon_error), 32'(err_m));
  endtask

  task automatic jtag_b(input logic [31:0] d, input string tag);
    jdo = 38'({$urandom, $urandom});
    jdo[34:3] = d;
    take_b = 1'b1;
    step();
    take_b = 1'b0;
    chk({tag, ".ready_lo"}, 32'(mon_ready), 32'd0);
    step();
    mem_m[jaddr_m] = d;
    jaddr_m = (jaddr_m + 1) % 256;
    chk({tag, ".ready"}, 32'(mon_ready), 32'd1);
    chk({tag, ".dreg_keep"}, MonDReg, dreg_m);
    step();
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d, input string tag);
    avs_address = 8'(a); avs_writedata = d; avs_write = 1'b1;
    #1;
    chk({tag, ".wait"}, 32'(avs_waitrequest), 32'd0);
    step();
    avs_write = 1'b0;
    if (!prot_m) mem_m[a] = d;
  endtask

  task automatic cpu_read(input int a, input string tag);
    int n;
    avs_address = 8'(a); avs_read = 1'b1; n = 0;
    #1;
    while (avs_waitrequest && n < 8) begin step(); n++; end
    chk({tag, ".lat"}, 32'(n), 32'd1);
    chk({tag, ".data"}, avs_readdata, mem_m[a]);
    step();
    avs_read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int a, n;
    reset = 1'b1; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    step(); step(); step();
    reset = 1'b0;
    chk("rst.dreg", MonDReg, 32'd0);
    chk("rst.ready", 32'(mon_ready), 32'd0);
    chk("rst.err", 32'(mon_error), 32'd0);
    chk("rst.wait", 32'(avs_waitrequest), 32'd0);
    chk("rst.rdata", avs_readdata, 32'd0);

    for (int i = 0; i < 256; i++) cpu_write(i, $urandom, "preload");
    cpu_write(5, 32'hCAFE0005, "pre5");

    jtag_a(mkjdo(5, 0, 0), "seta5");
    chk("seta5.val", MonDReg, 32'hCAFE0005);
    jtag_b(32'h11, "wr11");
    jtag_b(32'h22, "wr22");
    cpu_read(5, "rd5");
    cpu_read(6, "rd6");
    jtag_na("addr7");

    jtag_a(mkjdo(255, 0, 0), "seta255");
    jtag_na("wrap1");
    jtag_na("wrap0");
    chk("wrap0.val", MonDReg, mem_m[0]);

    jtag_a(mkjdo(300, 0, 0), "oor");
    jtag_a(mkjdo(7, 1, 0), "errclr");

    // JTAG write wins over a simultaneous CPU read, which then sees the new word.
    a = jaddr_m; d = $urandom;
    jdo = 38'({$urandom, $urandom}); jdo[34:3] = d;
    take_b = 1'b1; avs_read = 1'b1; avs_address = 8'(a);
    step();
    take_b = 1'b0;
    chk("cont.wait_jcmd", 32'(avs_waitrequest), 32'd1);
    mem_m[a] = d; jaddr_m = (jaddr_m + 1) % 256;
    n = 0;
    while (avs_waitrequest && n < 8) begin step(); n++; end
    chk("cont.lat", 32'(n), 32'd2);
    chk("cont.data", avs_readdata, d);
    step();
    avs_read = 1'b0;

    jdo = mkjdo(10, 0, 0); take_a = 1'b1;
    step();
    take_a = 1'b0; take_na = 1'b1;
    step();
    take_na = 1'b0;
    step();
    prot_m = 0; jaddr_m = 10; err_m = 1; dreg_m = mem_m[10];
    chk("drop.dreg", MonDReg, dreg_m);
    chk("drop.err", 32'(mon_error), 32'd1);
    step();
    jtag_na("drop.addr");
    jtag_a(mkjdo(20, 1, 0), "drop.clr");

    jtag_a(mkjdo(3, 0, 1), "prot.set");
    cpu_write(3, 32'hFF, "prot.cw");
    cpu_read(3, "prot.rd");
`ifdef OCIMON_WRPROT_EN
    chk("prot.kept", 32'(mem_m[3] == 32'hFF), 32'd0);
`endif
    jtag_b(32'h0BAD0003, "prot.jw");
    cpu_read(3, "prot.jrd");
    jtag_a(mkjdo(0, 0, 0), "prot.clr");

    // Reset in the middle of a JTAG write: write aborted, RAM kept, pointer back to 0.
    jtag_a(mkjdo(40, 0, 0), "mid.set");
    jdo = 38'({$urandom, $urandom}); jdo[34:3] = 32'hDEADBEEF;
    take_b = 1'b1;
    step();
    take_b = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    jaddr_m = 0; err_m = 0; prot_m = 0; dreg_m = '0;
    chk("mid.dreg", MonDReg, 32'd0);
    chk("mid.ready", 32'(mon_ready), 32'd0);
    cpu_read(40, "mid.ram");
    jtag_na("mid.addr0");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: jtag_a(mkjdo($urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), "rnd.a");
        1: jtag_na("rnd.na");
        2: jtag_b($urandom, "rnd.b");
        3: cpu_write($urandom_range(0, 255), $urandom, "rnd.cw");
        default: cpu_read($urandom_range(0, 255), "rnd.cr");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
